hazard_scoreboard: RTL and testbench

- Stall/issue controller for the decode stage of the pipelined processor.
- Tracks the destination register of every instruction in flight in EX, MEM and WB.
- Stalls decode when an instruction reads a register still pending, since forwarding is not present.
- Inserts bubbles into ID/EX, honours a global pipeline freeze and a branch flush, and keeps a stall-cycle performance counter.

---
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 79 +++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Decode-stage request and stall/issue response bundle for the
//               hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_rs_used;
  logic [2:0]       id_rs_sel;
  logic             id_rt_used;
  logic [2:0]       id_rt_sel;
  logic             id_wr_en;
  logic [2:0]       id_wr_sel;
  logic             pipe_stall;
  logic             flush;
  logic             stall;
  logic             issue;
  logic             bubble;
  logic [DEPTH-1:0] slot_valid;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs_used, id_rs_sel, id_rt_used, id_rt_sel,
    output id_wr_en, id_wr_sel, pipe_stall, flush,
    input  stall, issue, bubble, slot_valid, stall_count
  );

  modport slave (
    input  id_valid, id_rs_used, id_rs_sel, id_rt_used, id_rt_sel,
    input  id_wr_en, id_wr_sel, pipe_stall, flush,
    output stall, issue, bubble, slot_valid, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage stall/issue controller tracking in-flight writers.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int BYPASS_WB = 1,
  parameter int CNT_W     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hazard_scoreboard_if.slave sb
);

  localparam int NCMP = DEPTH - BYPASS_WB;

  logic [DEPTH-1:0] r_v;
  logic [2:0]       r_reg [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic w_hit_rs;
  logic w_hit_rt;
  logic w_hazard;

  always_comb begin
    w_hit_rs = 1'b0;
    w_hit_rt = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      w_hit_rs = w_hit_rs | (r_v[i] & (r_reg[i] == sb.id_rs_sel));
      w_hit_rt = w_hit_rt | (r_v[i] & (r_reg[i] == sb.id_rt_sel));
    end
    w_hazard = sb.id_valid & ((sb.id_rs_used & w_hit_rs) | (sb.id_rt_used & w_hit_rt));
  end

  // Bubble is suppressed while reset is held so ID/EX is not loaded from a flush.
  always_comb begin
    sb.stall  = 1'b0;
    sb.issue  = 1'b0;
    sb.bubble = 1'b0;
    if (sb.pipe_stall) begin
      sb.stall = 1'b1;
    end else if (sb.flush) begin
      sb.bubble = ~rst;
    end else if (w_hazard) begin
      sb.stall  = 1'b1;
      sb.bubble = ~rst;
    end else begin
      sb.issue = sb.id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i] <= 3'd0;
      end
    end else if (!sb.pipe_stall) begin
      r_v[0]   <= ~sb.flush & ~w_hazard & sb.id_valid & sb.id_wr_en;
      r_reg[0] <= sb.id_wr_sel;
      // A flush drops the entry leaving EX instead of advancing it to MEM.
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i]   <= (sb.flush && (i == 1)) ? 1'b0 : r_v[i-1];
        r_reg[i] <= r_reg[i-1];
      end
      if (w_hazard && !sb.flush && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sb.slot_valid  = r_v;
  assign sb.stall_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed and random checks of two scoreboard configurations
//               against an instruction-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t_valid, t_rsu, t_rtu, t_wen, t_ps, t_fl;
  logic [2:0] t_rs, t_rt, t_ws;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.DEPTH(3), .CNT_W(16)) bus0 ();
  hazard_scoreboard_if #(.DEPTH(3), .CNT_W(4))  bus1 ();

  assign bus0.id_valid   = t_valid;  assign bus1.id_valid   = t_valid;
  assign bus0.id_rs_used = t_rsu;    assign bus1.id_rs_used = t_rsu;
  assign bus0.id_rs_sel  = t_rs;     assign bus1.id_rs_sel  = t_rs;
  assign bus0.id_rt_used = t_rtu;    assign bus1.id_rt_used = t_rtu;
  assign bus0.id_rt_sel  = t_rt;     assign bus1.id_rt_sel  = t_rt;
  assign bus0.id_wr_en   = t_wen;    assign bus1.id_wr_en   = t_wen;
  assign bus0.id_wr_sel  = t_ws;     assign bus1.id_wr_sel  = t_ws;
  assign bus0.pipe_stall = t_ps;     assign bus1.pipe_stall = t_ps;
  assign bus0.flush      = t_fl;     assign bus1.flush      = t_fl;

  hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .sb  (bus0)
  );

  hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(0), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .sb  (bus1)
  );

  // Reference model: a list of issued register writers, each with its age in
  // pipeline stages after decode (0=EX, 1=MEM, 2=WB). cfg selects the DUT.
  typedef struct {
    int         cfg;
    int         age;
    logic [2:0] rg;
  } ent_t;

  ent_t q[$];
  int   m_cnt[2];
  int   ncmp[2] = '{2, 3};
  int   cap[2]  = '{65535, 15};

  function automatic bit pend(int k, logic [2:0] r);
    foreach (q[j]) if (q[j].cfg == k && q[j].age < ncmp[k] && q[j].rg == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit haz(int k);
    return t_valid && ((t_rsu && pend(k, t_rs)) || (t_rtu && pend(k, t_rt)));
  endfunction

  // {stall, issue, bubble}
  function automatic logic [2:0] exp_out(int k);
    if (t_ps) return 3'b100;
    if (t_fl) return {2'b00, ~rst};
    if (haz(k)) return 3'b101;
    return {1'b0, t_valid, 1'b0};
  endfunction

  function automatic logic [2:0] exp_sv(int k);
    logic [2:0] s = 3'b000;
    foreach (q[j]) if (q[j].cfg == k) s[q[j].age] = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = '{0, 0};
  endtask

  task automatic model_clock();
    ent_t nq[$];
    ent_t e;
    bit   h[2];
    if (rst) begin
      model_reset();
      return;
    end
    if (t_ps) return;
    for (int k = 0; k < 2; k++) h[k] = haz(k);
    foreach (q[j]) begin
      e = q[j];
      e.age++;
      if (e.age < 3 && !(t_fl && e.age == 1)) nq.push_back(e);
    end
    for (int k = 0; k < 2; k++) begin
      if (!t_fl && !h[k] && t_valid && t_wen) begin
        e.cfg = k; e.age = 0; e.rg = t_ws;
        nq.push_back(e);
      end
      if (!t_fl && h[k] && m_cnt[k] < cap[k]) m_cnt[k]++;
    end
    q = nq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] e0, e1;
    e0 = exp_out(0);
    e1 = exp_out(1);
    chk("d0_stall",  32'(bus0.stall),       32'(e0[2]));
    chk("d0_issue",  32'(bus0.issue),       32'(e0[1]));
    chk("d0_bubble", 32'(bus0.bubble),      32'(e0[0]));
    chk("d0_slotv",  32'(bus0.slot_valid),  32'(exp_sv(0)));
    chk("d0_count",  32'(bus0.stall_count), m_cnt[0]);
    chk("d1_stall",  32'(bus1.stall),       32'(e1[2]));
    chk("d1_issue",  32'(bus1.issue),       32'(e1[1]));
    chk("d1_bubble", 32'(bus1.bubble),      32'(e1[0]));
    chk("d1_slotv",  32'(bus1.slot_valid),  32'(exp_sv(1)));
    chk("d1_count",  32'(bus1.stall_count), m_cnt[1]);
  endtask

  task automatic do_cycle();
    #1 check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input bit rsu, input logic [2:0] rs, input bit rtu,
                     input logic [2:0] rt, input bit we, input logic [2:0] ws,
                     input bit ps = 1'b0, input bit fl = 1'b0);
    t_valid = v; t_rsu = rsu; t_rs = rs; t_rtu = rtu; t_rt = rt;
    t_wen = we; t_ws = ws; t_ps = ps; t_fl = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    do_cycle();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk("rst_slotv", 32'(bus0.slot_valid), 0);
    chk("rst_count", 32'(bus0.stall_count), 0);
    do_reset();

    // Back-to-back dependency: producer r3, consumer reads r3.
    drv(1, 1, 3'd1, 1, 3'd2, 1, 3'd3);
    #1 chk("t1_issue_prod", 32'(bus0.issue), 1);
    do_cycle();
    drv(1, 1, 3'd3, 1, 3'd1, 1, 3'd4);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t1_stall", 32'({bus0.stall, bus0.bubble}), 3);
      do_cycle();
    end
    #1 chk("t1_issue_cons", 32'(bus0.issue), 1);
    do_cycle();
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t1_count", 32'(bus0.stall_count), 2);
    do_cycle();

    // Producer already in WB: bypassed in dut0, one stall in dut1.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3'd5); do_cycle();
    drv(1, 0, 0, 0, 0, 1, 3'd6); do_cycle();
    drv(1, 0, 0, 0, 0, 1, 3'd7); do_cycle();
    drv(1, 1, 3'd5, 0, 0, 0, 0);
    #1 chk("t2_bypass", 32'({bus0.stall, bus0.issue}), 1);
    chk("t2_nobypass_stall", 32'(bus1.stall), 1);
    do_cycle();
    #1 chk("t2_nobypass_issue", 32'(bus1.issue), 1);
    do_cycle();

    // Freeze on top of a pending hazard.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3'd2); do_cycle();
    drv(1, 1, 3'd2, 0, 0, 1, 3'd3, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_frz_out", 32'({bus0.stall, bus0.bubble, bus0.issue}), 4);
      chk("t3_frz_slotv", 32'(bus0.slot_valid), 1);
      chk("t3_frz_count", 32'(bus0.stall_count), 0);
      do_cycle();
    end
    drv(1, 1, 3'd2, 0, 0, 1, 3'd3);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t3_haz", 32'({bus0.stall, bus0.bubble}), 3);
      do_cycle();
    end
    #1 chk("t3_issue", 32'(bus0.issue), 1);
    do_cycle();
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t3_count", 32'(bus0.stall_count), 2);
    do_cycle();

    // Flush squashes the EX producer so the reader proceeds next cycle.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3'd6); do_cycle();
    drv(1, 1, 3'd6, 0, 0, 0, 0, 0, 1);
    #1 chk("t4_flush", 32'({bus0.stall, bus0.issue, bus0.bubble}), 1);
    do_cycle();
    drv(1, 1, 3'd6, 1, 3'd6, 0, 0);
    #1 chk("t4_issue", 32'(bus0.issue), 1);
    chk("t4_slotv", 32'(bus0.slot_valid), 0);
    do_cycle();

    // Self-dependent chain: counter saturation in the 4-bit instance.
    do_reset();
    drv(1, 1, 3'd1, 0, 0, 1, 3'd1);
    repeat (40) do_cycle();
    #1 chk("t5_sat", 32'(bus1.stall_count), 15);
    chk("t5_count", 32'(bus0.stall_count), 26);
    drv(0, 0, 0, 0, 0, 0, 0);
    do_cycle();

    // Asynchronous reset in the middle of a hazard stall.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3'd1); do_cycle();
    drv(1, 1, 3'd1, 0, 0, 0, 0); do_cycle();
    #1 chk("t6_pre_count", 32'(bus0.stall_count), 1);
    #1 rst = 1'b1;
    model_reset();
    #1 chk("t6_slotv", 32'(bus0.slot_valid), 0);
    chk("t6_count", 32'(bus0.stall_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t6_issue", 32'(bus0.issue), 1);
    do_cycle();

    // Random traffic on a small register range to provoke frequent hits.
    repeat (400) begin
      rst = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      drv(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      do_cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
